// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, memory geometry
// and the padding word.
package imem_pkg;

   localparam int          IMEM_DEPTH  = 64;
   localparam int          IMEM_ADDR_W = 6;
   localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_RECV,
      ST_WRITE,
      ST_FILL,
      ST_DONE,
      ST_ERR
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in (valid/ready) and imem write port out, bundled for the loader.
// The master side is the loader; the slave side is the host stream plus the memory.
interface imem_loader_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Packs four accepted bytes into a 32-bit word; word_valid flags the beat that
// completes the word, so the packed value is ready on the following cycle.
module byte_word_packer #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 2'd0;
         word_q <= 32'd0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      word_d     = word_q;
      word_valid = 1'b0;
      if (clear) begin
         cnt_d  = 2'd0;
         word_d = 32'd0;
      end else if (byte_valid) begin
         cnt_d      = cnt_q + 2'd1;
         word_valid = (cnt_q == 2'd3);
         // Big-endian shifts toward the MSB; little-endian fills from the top down.
         if (BIG_ENDIAN)
            word_d = {word_q[23:0], byte_data};
         else
            word_d = {byte_data, word_q[31:8]};
      end
   end

   assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a counted byte stream into the instruction memory as 32-bit words,
// optionally pads the rest with NOPs, and holds the CPU in reset meanwhile.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH      = IMEM_DEPTH,
   parameter int ADDR_W     = IMEM_ADDR_W,
   parameter bit BIG_ENDIAN = 1'b1,
   parameter bit ZERO_FILL  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_start,
   imem_loader_if.master    bus,
   output logic             cpu_hold,
   output logic             load_done,
   output logic             load_err,
   output logic [ADDR_W:0]  words_written
);

   localparam int                IDX_W   = ADDR_W + 1;
   localparam logic [IDX_W-1:0]  DEPTH_I = IDX_W'(DEPTH);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] written_q, written_d;
   logic [IDX_W-1:0] idx_inc;

   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_wdata;
   logic        pack_clear;
   logic        pack_valid;
   logic [31:0] pack_word;
   logic        count_bad;

   byte_word_packer #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pack_clear),
      .byte_valid (bus.rx_valid && (state_q == ST_RECV)),
      .byte_data  (bus.rx_data),
      .word       (pack_word),
      .word_valid (pack_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         idx_q     <= '0;
         written_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         written_q <= written_d;
      end
   end

   assign idx_inc   = idx_q + IDX_W'(1);
   assign count_bad = (bus.rx_data == 8'd0) || ({24'd0, bus.rx_data} > 32'(DEPTH));

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      written_d  = written_q;
      pack_clear = 1'b0;
      rx_ready   = 1'b0;
      imem_we    = 1'b0;
      imem_wdata = NOP_WORD;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            // DONE lasts one cycle so load_done is a pulse; it behaves like IDLE otherwise.
            if (state_q == ST_DONE)
               state_d = ST_IDLE;
            if (load_start) begin
               state_d    = ST_COUNT;
               count_d    = '0;
               idx_d      = '0;
               written_d  = '0;
               pack_clear = 1'b1;
            end
         end
         ST_COUNT: begin
            rx_ready = 1'b1;
            if (bus.rx_valid) begin
               if (count_bad) begin
                  state_d = ST_ERR;
               end else begin
                  count_d = IDX_W'(bus.rx_data);
                  state_d = ST_RECV;
               end
            end
         end
         ST_RECV: begin
            rx_ready = 1'b1;
            if (pack_valid)
               state_d = ST_WRITE;
         end
         ST_WRITE: begin
            imem_we    = 1'b1;
            imem_wdata = pack_word;
            idx_d      = idx_inc;
            written_d  = written_q + IDX_W'(1);
            if (idx_inc < count_q)
               state_d = ST_RECV;
            else if (ZERO_FILL && (count_q < DEPTH_I))
               state_d = ST_FILL;
            else
               state_d = ST_DONE;
         end
         ST_FILL: begin
            imem_we   = 1'b1;
            idx_d     = idx_inc;
            written_d = written_q + IDX_W'(1);
            if (idx_inc == DEPTH_I)
               state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.rx_ready   = rx_ready;
   assign bus.imem_we    = imem_we;
   assign bus.imem_wdata = imem_wdata;
   assign bus.imem_addr  = imem_we ? {{(30 - IDX_W){1'b0}}, idx_q, 2'b00} : 32'd0;

   assign cpu_hold      = !((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign load_done     = (state_q == ST_DONE);
   assign load_err      = (state_q == ST_ERR);
   assign words_written = written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default (big-endian, zero-fill) instance and a
// little-endian, no-fill instance, each with a write monitor and hand-computed vectors.
module tb_imem_loader;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic load_start_a = 1'b0, load_start_b = 1'b0;
   logic cpu_hold_a, load_done_a, load_err_a;
   logic cpu_hold_b, load_done_b, load_err_b;
   logic [6:0] ww_a, ww_b;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int acc_a = 0;
   int done_cyc_b = -1;
   wr_t wq_a[$];
   wr_t wq_b[$];

   imem_loader_if bus_a ();
   imem_loader_if bus_b ();

   imem_loader u_dut (
      .clk           (clk),
      .reset         (reset),
      .load_start    (load_start_a),
      .bus           (bus_a),
      .cpu_hold      (cpu_hold_a),
      .load_done     (load_done_a),
      .load_err      (load_err_a),
      .words_written (ww_a)
   );

   imem_loader #(
      .BIG_ENDIAN (1'b0),
      .ZERO_FILL  (1'b0)
   ) u_dut_le (
      .clk           (clk),
      .reset         (reset),
      .load_start    (load_start_b),
      .bus           (bus_b),
      .cpu_hold      (cpu_hold_b),
      .load_done     (load_done_b),
      .load_err      (load_err_b),
      .words_written (ww_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus_a.imem_we) wq_a.push_back('{bus_a.imem_addr, bus_a.imem_wdata, cyc});
      if (bus_b.imem_we) wq_b.push_back('{bus_b.imem_addr, bus_b.imem_wdata, cyc});
      if (bus_a.rx_valid && bus_a.rx_ready) acc_a++;
      if (load_done_b) done_cyc_b = cyc;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic pulse_start(input bit sel);
      @(negedge clk);
      if (sel) load_start_b = 1'b1; else load_start_a = 1'b1;
      @(negedge clk);
      load_start_a = 1'b0;
      load_start_b = 1'b0;
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
      int n;
      logic rdy;
      repeat (gap) @(negedge clk);
      if (sel) begin
         bus_b.rx_data = b; bus_b.rx_valid = 1'b1;
      end else begin
         bus_a.rx_data = b; bus_a.rx_valid = 1'b1;
      end
      n = 0;
      rdy = sel ? bus_b.rx_ready : bus_a.rx_ready;
      while (!rdy && n < 200) begin
         @(negedge clk);
         n++;
         rdy = sel ? bus_b.rx_ready : bus_a.rx_ready;
      end
      check_eq($sformatf("rx_accept %h", b), {31'd0, rdy}, 32'd1);
      @(negedge clk);
      bus_a.rx_valid = 1'b0;
      bus_b.rx_valid = 1'b0;
   endtask

   task automatic wait_done_a();
      int  n;
      logic prev_hold;
      n = 0;
      prev_hold = cpu_hold_a;
      while (!load_done_a && n < 300) begin
         prev_hold = cpu_hold_a;
         @(negedge clk);
         n++;
      end
      check_eq("load_done_seen", {31'd0, load_done_a}, 32'd1);
      check_eq("hold_before_done", {31'd0, prev_hold}, 32'd1);
      check_eq("hold_at_done", {31'd0, cpu_hold_a}, 32'd0);
      check_eq("words_written", {25'd0, ww_a}, 32'd64);
      @(negedge clk);
      check_eq("done_one_cycle", {31'd0, load_done_a}, 32'd0);
   endtask

   task automatic check_scenario1(input string tag);
      check_eq({tag, " nwrites"}, wq_a.size(), 32'd64);
      check_eq({tag, " bytes_accepted"}, acc_a, 32'd9);
      for (int i = 0; i < wq_a.size() && i < 64; i++) begin
         check_eq($sformatf("%s addr[%0d]", tag, i), wq_a[i].addr, 32'(4 * i));
         case (i)
            0:       check_eq($sformatf("%s data[0]", tag), wq_a[i].data, 32'h8C01_0000);
            1:       check_eq($sformatf("%s data[1]", tag), wq_a[i].data, 32'h8C02_0004);
            default: check_eq($sformatf("%s data[%0d]", tag, i), wq_a[i].data, 32'h0000_0000);
         endcase
      end
   endtask

   task automatic send_scenario1(input int max_gap, input int skip);
      logic [7:0] bytes [9];
      bytes = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'h8C, 8'h02, 8'h00, 8'h04};
      for (int i = skip; i < 9; i++)
         send_byte(1'b0, bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, " rx_ready"}, {31'd0, bus_a.rx_ready}, 32'd0);
      check_eq({tag, " imem_we"}, {31'd0, bus_a.imem_we}, 32'd0);
      check_eq({tag, " imem_addr"}, bus_a.imem_addr, 32'd0);
      check_eq({tag, " imem_wdata"}, bus_a.imem_wdata, 32'd0);
      check_eq({tag, " cpu_hold"}, {31'd0, cpu_hold_a}, 32'd0);
      check_eq({tag, " load_done"}, {31'd0, load_done_a}, 32'd0);
      check_eq({tag, " load_err"}, {31'd0, load_err_a}, 32'd0);
      check_eq({tag, " words_written"}, {25'd0, ww_a}, 32'd0);
   endtask

   initial begin
      bus_a.rx_data = 8'h00; bus_a.rx_valid = 1'b0;
      bus_b.rx_data = 8'h00; bus_b.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_state("reset");

      // Test 1: two payload words then NOP padding to the end of imem.
      pulse_start(1'b0);
      check_eq("t1 hold_in_count", {31'd0, cpu_hold_a}, 32'd1);
      check_eq("t1 ready_in_count", {31'd0, bus_a.rx_ready}, 32'd1);
      send_scenario1(0, 0);
      wait_done_a();
      check_scenario1("t1");

      // Test 2: bad counts land in ERR with no writes; load_start clears the error.
      wq_a.delete(); acc_a = 0;
      pulse_start(1'b0);
      send_byte(1'b0, 8'h00, 0);
      check_eq("t2 err_zero", {31'd0, load_err_a}, 32'd1);
      check_eq("t2 hold_zero", {31'd0, cpu_hold_a}, 32'd1);
      bus_a.rx_valid = 1'b1; bus_a.rx_data = 8'h55;
      repeat (4) @(negedge clk);
      check_eq("t2 ready_in_err", {31'd0, bus_a.rx_ready}, 32'd0);
      bus_a.rx_valid = 1'b0;
      pulse_start(1'b0);
      check_eq("t2 err_cleared", {31'd0, load_err_a}, 32'd0);
      send_byte(1'b0, 8'h41, 0);
      check_eq("t2 err_65", {31'd0, load_err_a}, 32'd1);
      check_eq("t2 hold_65", {31'd0, cpu_hold_a}, 32'd1);
      check_eq("t2 no_writes", wq_a.size(), 32'd0);
      pulse_start(1'b0);
      check_eq("t2 err_cleared2", {31'd0, load_err_a}, 32'd0);

      // Test 3: scenario 1 with random gaps, continuing from the COUNT state above.
      acc_a = 0;
      send_scenario1(5, 0);
      wait_done_a();
      check_scenario1("t3");

      // Test 4: reset in the middle of the second word aborts the load.
      wq_a.delete(); acc_a = 0;
      pulse_start(1'b0);
      send_byte(1'b0, 8'h02, 0);
      send_byte(1'b0, 8'h8C, 0);
      send_byte(1'b0, 8'h01, 0);
      send_byte(1'b0, 8'h00, 0);
      send_byte(1'b0, 8'h00, 0);
      send_byte(1'b0, 8'h8C, 0);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("t4 after_reset");
      reset = 1'b0;
      wq_a.delete(); acc_a = 0;
      pulse_start(1'b0);
      send_scenario1(0, 0);
      wait_done_a();
      check_scenario1("t4");

      // Test 5: load_start while receiving is ignored.
      wq_a.delete(); acc_a = 0;
      pulse_start(1'b0);
      send_byte(1'b0, 8'h02, 0);
      send_byte(1'b0, 8'h8C, 0);
      send_byte(1'b0, 8'h01, 0);
      pulse_start(1'b0);
      check_eq("t5 ready_kept", {31'd0, bus_a.rx_ready}, 32'd1);
      check_eq("t5 hold_kept", {31'd0, cpu_hold_a}, 32'd1);
      check_eq("t5 ww_kept", {25'd0, ww_a}, 32'd0);
      send_scenario1(0, 3);
      wait_done_a();
      check_scenario1("t5");

      // Test 6: little-endian, no fill, single word.
      wq_b.delete(); done_cyc_b = -1;
      pulse_start(1'b1);
      send_byte(1'b1, 8'h01, 0);
      send_byte(1'b1, 8'h00, 0);
      send_byte(1'b1, 8'h00, 0);
      send_byte(1'b1, 8'h01, 0);
      send_byte(1'b1, 8'h8C, 0);
      repeat (4) @(negedge clk);
      check_eq("t6 nwrites", wq_b.size(), 32'd1);
      if (wq_b.size() > 0) begin
         check_eq("t6 addr", wq_b[0].addr, 32'd0);
         check_eq("t6 data", wq_b[0].data, 32'h8C01_0000);
         check_eq("t6 done_latency", done_cyc_b, wq_b[0].cyc + 1);
      end
      check_eq("t6 words_written", {25'd0, ww_b}, 32'd1);
      check_eq("t6 hold_released", {31'd0, cpu_hold_b}, 32'd0);
      check_eq("t6 no_err", {31'd0, load_err_b}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
